// File: rtl/disp_scan_mux.sv
// Time-multiplexed seven-segment digit scanner with shadow capture, prescaled scan and frame marker.
// Optional leading-zero blanking: define DISP_SCAN_BLANK_EN. The digit field port is 'fld' because 'do' is a reserved word.
module disp_scan_mux #(
  parameter int NDIG  = 4,
  parameter int DW    = 4,
  parameter int PRESC = 50000,
  localparam int AW   = $clog2(NDIG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NDIG*DW-1:0]   dat,
  input  logic [NDIG-1:0]      dp_in,
  input  logic                 ld,
  input  logic                 en,
  output logic [DW-1:0]        fld,
  output logic [NDIG-1:0]      an,
  output logic                 dp,
  output logic [AW-1:0]        adr,
  output logic                 frame
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESC - 1);
  localparam logic [AW-1:0] ADR_LAST = AW'(NDIG - 1);

  logic [CW-1:0]      cnt;
  logic [NDIG*DW-1:0] sh_dat;
  logic [NDIG-1:0]    sh_dp;
  logic               tick;
  logic               wrap;
  logic [DW-1:0]      fld_nxt;
  logic               dp_nxt;
  logic [NDIG-1:0]    sel;
  logic [NDIG-1:0]    lit;
  logic [NDIG-1:0]    an_nxt;

  assign tick = en && (cnt == CNT_LAST);
  assign wrap = tick && (adr == ADR_LAST);

  // Digit select from the current index; the explicit compare keeps non-power-of-2 NDIG safe.
  always_comb begin
    fld_nxt = '0;
    dp_nxt  = 1'b1;
    sel     = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (adr == AW'(i)) begin
        sel[i]  = 1'b1;
        fld_nxt = sh_dat[i*DW +: DW];
        dp_nxt  = ~sh_dp[i];
      end
    end
  end

`ifdef DISP_SCAN_BLANK_EN
  logic [NDIG-1:0] blank;
  logic            zero_run;

  // A digit is blank only if it and every more significant digit is zero with no decimal point.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run = zero_run & (sh_dat[i*DW +: DW] == '0) & ~sh_dp[i];
      blank[i] = zero_run;
    end
  end

  assign lit = sel & ~blank;
`else
  assign lit = sel;
`endif

  assign an_nxt = en ? ~lit : '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      adr    <= '0;
      sh_dat <= '0;
      sh_dp  <= '0;
      fld    <= '0;
      an     <= '1;
      dp     <= 1'b1;
      frame  <= 1'b0;
    end else begin
      if (ld) begin
        sh_dat <= dat;
        sh_dp  <= dp_in;
      end
      if (tick) begin
        cnt <= '0;
        adr <= (adr == ADR_LAST) ? '0 : adr + 1'b1;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
      // Output stage: registered from the index and shadow as they stood before this edge.
      frame <= wrap;
      fld   <= fld_nxt;
      dp    <= dp_nxt;
      an    <= an_nxt;
    end
  end

endmodule

// File: doc/disp_scan_mux.md
# disp_scan_mux

Time-multiplexed digit scanner for multi-digit seven-segment displays. It holds a shadow copy of an NDIG×DW data word and steps through the digits at a programmable rate. For each digit it drives the selected field, an active-low one-hot anode and an active-low decimal point. It sits between the data-producing logic and the segment decoder, generalising the fixed 4-digit nibble selector with a scan counter, a capture strobe, an enable and a frame marker.

## Interface
- NDIG, 4: number of digits; legal range 2..16.
- DW, 4: bits per digit field.
- PRESC, 50000: clock cycles per digit slot; legal range ≥1.
- AW, derived: $clog2(NDIG) (localparam).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- dat  in  NDIG*DW  display word; digit i = dat[i*DW +: DW]; digit 0 is least significant.
- dp_in  in  NDIG  decimal point request per digit, active-high.
- ld  in  1  capture strobe; loads dat and dp_in into the shadow register.
- en  in  1  scan enable.
- do  out  DW  field of the current digit (registered).
- an  out  NDIG  anode select, active-low one-hot (registered).
- dp  out  1  decimal point, active-low (registered).
- adr  out  AW  current digit index.
- frame  out  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Reset (rst_n=0 at an edge):
  - Internal state: cnt=0, adr=0, shadow data=0, shadow dp=0.
  - Outputs: do=0, an=all ones, dp=1, frame=0.
- Shadow: when ld=1, the shadow register takes dat/dp_in at that edge. Otherwise it holds. The display reads only the shadow, never dat directly.
- Prescaler: cnt counts 0..PRESC-1 while en=1. A tick occurs on an edge where cnt==PRESC-1 and en=1; cnt then returns to 0. With PRESC=1, every enabled cycle is a tick.
- Digit counter: on a tick, adr advances by 1. From NDIG-1 it wraps to 0, including when NDIG is not a power of 2.
- frame=1 for exactly the cycle after an edge where adr went NDIG-1→0; otherwise 0.
- Output stage, updated every edge from the current adr and shadow:
  - do = shadow field[adr].
  - dp = ~shadow_dp[adr].
  - an = ~(1<<adr) when en=1; all ones when en=0.
- en=0: cnt and adr freeze, an is blanked, frame=0. Resuming continues from the frozen cnt/adr.
- ld on the same edge as a tick: both take effect. The next digit shows the new data.
- Reset mid-scan: the scan restarts at digit 0 with a full PRESC slot.

## Timing
- ld at edge k → shadow updated at k → do/dp reflect the new data at edge k+1.
- Tick at edge k → adr updated at k → do/an/dp for the new digit at edge k+1.
- Enabled digit period: PRESC cycles. Frame period: NDIG*PRESC cycles.
- en falling at edge k → an all ones from edge k+1.

## Configuration
- DISP_SCAN_BLANK_EN: leading-zero blanking.
  - Defined: digit i (i≥1) is blanked (an bit held 1) when shadow fields i..NDIG-1 are all zero and shadow_dp bits i..NDIG-1 are all 0. Digit 0 is never blanked. Blanking is evaluated from the shadow in the output stage, with the same one-cycle latency.
  - Undefined: every digit's anode is driven when selected; the blanking logic is absent.

## Test plan
- Reset: hold rst_n=0 three cycles with en=1, ld=1 → do=0, an=4'b1111, dp=1, adr=0, frame=0 throughout; no capture.
- Scan order (NDIG=4, PRESC=4): ld with dat=16'h1234, dp_in=4'b0100, en=1 → do sequence 4,3,2,1 with 4 cycles each; an 1110,1101,1011,0111; dp=0 only while an=1011; frame high one cycle every 16 cycles, aligned with adr→0.
- Mid-scan load: during digit 2, ld with dat=16'hABCD → next slot shows do=A on an=0111; no field mixes old/new data on the wrap.
- Enable: drop en for 10 cycles mid-slot → an=1111 from the next edge; adr/cnt frozen; on resume the slot completes its remaining count.
- Simultaneous tick+ld, PRESC=1: ld at a tick edge → next digit shows new data one cycle later; frame pulses every 4 cycles.
- With DISP_SCAN_BLANK_EN, dat=16'h0045:
  - dp_in=0 → digits 3,2 show an bit=1; digits 1,0 lit (4,5).
  - dp_in=4'b0100 → digit 2 lit (do=0, dp=0), digit 3 blank.
  - dat=0 → only digit 0 lit.
